melody_sequencer: RTL and testbench

Plays a melody stored in a small writable note memory and drives the tone generator's `period` input, one note at a time. Each entry holds a tone period in microseconds and a duration in milliseconds. The block counts durations against a millisecond tick derived from the system clock, inserts an optional silent gap between notes, and supports one-shot or looped playback with start/stop control. It sits directly upstream of the tone generator: `period` feeds the generator and `tone_en` gates its buzzer output.

---
 rtl/melody_sequencer.sv | 138 +++++++++++++
 tb/tb_melody_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - note-memory melody player driving the tone generator period
module melody_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int MS_CYCLES = 50000,
  parameter int GAP_MS    = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW:0]   length,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [31:0]   period,
  output logic          tone_en,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);
  localparam int            PW      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [PW-1:0] MS_LAST = PW'(MS_CYCLES - 1);
  localparam logic [11:0]   GAP_LEN = 12'(GAP_MS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;
  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   entry;
  logic [AW:0]   len_q;
  logic [PW-1:0] ms_cnt;
  logic [11:0]   dur_cnt;
  logic          tick, seg_last, has_next;
  logic          go, empty_start, abort, enter_gap, next_note, wrap, finish;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The LOAD->PLAY edge captures the entry into period/dur_cnt, acting as the read register.
  assign entry    = mem[note_idx];
  assign tick     = (ms_cnt == MS_LAST);
  assign seg_last = tick && (dur_cnt == 12'd1);
  assign has_next = ({1'b0, note_idx} + (AW+1)'(1)) < len_q;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    go          = 1'b0;
    empty_start = 1'b0;
    abort       = 1'b0;
    enter_gap   = 1'b0;
    next_note   = 1'b0;
    wrap        = 1'b0;
    finish      = 1'b0;
    if (busy && stop) begin
      abort     = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (length != '0) begin
              go        = 1'b1;
              state_nxt = S_LOAD;
            end else begin
              empty_start = 1'b1;
            end
          end
        end
        S_LOAD: state_nxt = S_PLAY;
        S_PLAY, S_GAP: begin
          if (seg_last) begin
            if (state == S_PLAY && GAP_MS > 0) begin
              enter_gap = 1'b1;
              state_nxt = S_GAP;
            end else if (has_next) begin
              next_note = 1'b1;
              state_nxt = S_LOAD;
            end else if (loop) begin
              wrap      = 1'b1;
              state_nxt = S_LOAD;
            end else begin
              finish    = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period   <= '0;
      tone_en  <= 1'b0;
      note_idx <= '0;
      done     <= 1'b0;
      len_q    <= '0;
      ms_cnt   <= '0;
      dur_cnt  <= '0;
    end else begin
      done <= empty_start | finish;
      if (go) begin
        note_idx <= '0;
        len_q    <= length;
      end
      if (abort || finish) begin
        period   <= '0;
        tone_en  <= 1'b0;
        note_idx <= '0;
      end else if (state == S_LOAD) begin
        period  <= {12'b0, entry[19:0]};
        tone_en <= (entry[19:0] != 20'd0);
        dur_cnt <= (entry[31:20] == 12'd0) ? 12'd1 : entry[31:20];
        ms_cnt  <= '0;
      end else if (enter_gap) begin
        tone_en <= 1'b0;
        dur_cnt <= GAP_LEN;
        ms_cnt  <= '0;
      end else if (next_note || wrap) begin
        tone_en  <= 1'b0;
        note_idx <= wrap ? '0 : note_idx + AW'(1);
      end else if (state == S_PLAY || state == S_GAP) begin
        ms_cnt <= tick ? '0 : ms_cnt + PW'(1);
        if (tick) dur_cnt <= dur_cnt - 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - randomized self-checking bench for melody_sequencer
module tb_melody_sequencer;
  localparam int MS  = 4;
  localparam int GAP = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  length = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] period;
  logic        tone_en, busy, done;
  logic [3:0]  note_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [16];
  logic [38:0] exp_q [$];

  melody_sequencer #(.DEPTH(16), .AW(4), .MS_CYCLES(MS), .GAP_MS(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .loop(loop), .start(start), .stop(stop), .period(period),
    .tone_en(tone_en), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [38:0] pack(input bit b, input bit t, input bit d, input int idx,
                                       input logic [31:0] p);
    return {b, t, d, 4'(idx), p};
  endfunction

  // note_idx after natural completion is not defined, so it is only compared while busy
  function automatic logic [38:0] observe(input bit exp_busy);
    return {busy, tone_en, done, exp_busy ? note_idx : 4'd0, period};
  endfunction

  // Expected per-cycle timeline: LOAD, d*MS sounding cycles, GAP*MS silent cycles per note
  function automatic void build(input int len, input int passes, input bit ends);
    logic [31:0] prev;
    logic [19:0] p;
    int d;
    prev = '0;
    exp_q.delete();
    for (int ps = 0; ps < passes; ps++) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(pack(1, 0, 0, i, prev));
        p = mdl_mem[i][19:0];
        d = (mdl_mem[i][31:20] == 12'd0) ? 1 : int'(mdl_mem[i][31:20]);
        for (int c = 0; c < (d + GAP) * MS; c++)
          exp_q.push_back(pack(1, (c < d * MS) && (p != 20'd0), 0, i, {12'b0, p}));
        prev = {12'b0, p};
      end
    end
    if (ends) begin
      exp_q.push_back(pack(0, 0, 1, 0, '0));
      exp_q.push_back(pack(0, 0, 0, 0, '0));
    end
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(posedge CLK); #1;
    wr_en = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic run(input string name, input int len, input bit lp, input int n_check,
                     input int wr_at, input logic [3:0] wa, input logic [31:0] wd);
    length = 5'(len); loop = lp; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < exp_q.size() && (n_check < 0 || k < n_check); k++) begin
      @(negedge CLK);
      check($sformatf("%s cyc%0d", name, k), 64'(observe(exp_q[k][38])), 64'(exp_q[k]));
      wr_en = (k == wr_at); wr_addr = wa; wr_data = wd;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_stop(input string name);
    stop = 1'b1;
    @(posedge CLK); #1;
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("%s idle%0d", name, k), 64'({busy, tone_en, done, note_idx, period}), 64'd0);
    end
  endtask

  initial begin
    #2;
    check("reset", 64'({busy, tone_en, done, note_idx, period}), 64'd0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

    // basic melody
    wr(0, {12'd2, 20'd1000});
    wr(1, {12'd1, 20'd0});
    build(2, 1, 1);
    run("basic", 2, 0, -1, -1, 0, 0);

    // looped playback for two passes, then abort
    build(2, 2, 0);
    run("loop", 2, 1, -1, -1, 0, 0);
    do_stop("loop_stop");

    // stop during the first note
    build(2, 1, 1);
    run("stopmid", 2, 0, 4, -1, 0, 0);
    do_stop("stopmid");

    // length 0 gives only a done pulse
    @(negedge CLK);
    length = '0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("len0 pulse", 64'({busy, done}), 64'b01);
    @(negedge CLK);
    check("len0 after", 64'({busy, done}), 64'b00);

    // start together with stop while idle
    length = 5'd2; start = 1'b1; stop = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("startstop%0d", k), 64'({busy, tone_en, done, period}), 64'd0);
    end

    // zero duration counts as one millisecond
    wr(0, {12'd0, 20'd123});
    build(1, 1, 1);
    run("dur0", 1, 0, -1, -1, 0, 0);

    // rewrite entry 1 while entry 0 is sounding
    wr(0, {12'd1, 20'd700});
    wr(1, {12'd1, 20'd900});
    mdl_mem[1] = {12'd1, 20'd500};
    build(2, 1, 1);
    run("wrplay", 2, 0, -1, 2, 4'd1, {12'd1, 20'd500});

    // randomized melodies
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        wr(i, {12'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF))});
      build(len, 1, 1);
      run($sformatf("rand%0d", r), len, 0, -1, -1, 0, 0);
    end

    // asynchronous reset in the middle of a note
    wr(0, {12'd2, 20'd4321});
    build(1, 1, 1);
    run("rstmid", 1, 0, 5, -1, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst async", 64'({busy, tone_en, done, note_idx, period}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst held", 64'({busy, tone_en, done, note_idx, period}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
